alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/uurisc_pkg.sv | 39 +++
 rtl/alu_ctrl_alu.sv | 52 +++++
 rtl/alu_ctrl.sv | 114 +++++++++++
 tb/tb_alu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uurisc_pkg.sv
// ============================================================================
// Module : uurisc_pkg
// Brief  : Shared ALU op-codes, flag layout and alu_ctrl FSM state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uurisc_pkg;

    localparam int unsigned ALU_OP_LAST   = 9;
    localparam int unsigned ALU_FLAG_BITS = 3;

    // Flag bit positions: carry/borrow, zero, negative (result MSB)
    localparam int unsigned ALU_FLAG_C = 0;
    localparam int unsigned ALU_FLAG_Z = 1;
    localparam int unsigned ALU_FLAG_N = 2;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SRL  = 4'd2,
        SLL  = 4'd3,
        OR   = 4'd4,
        NOR  = 4'd5,
        AND  = 4'd6,
        NAND = 4'd7,
        XOR  = 4'd8,
        NOT  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_alu.sv
// ============================================================================
// Module : alu_ctrl_alu
// Brief  : Combinational ALU; flags = {negative, zero, carry/borrow}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_alu
    import uurisc_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]    i_a,
    input  logic [DATA_WIDTH-1:0]    i_b,
    input  alu_op_t                  i_op,
    output logic [DATA_WIDTH-1:0]    o_dout,
    output logic [ALU_FLAG_BITS-1:0] o_flags
);

    logic w_carry;

    always_comb begin
        w_carry = 1'b0;
        o_dout  = '0;
        case (i_op)
            ADD:  {w_carry, o_dout} = {1'b0, i_a} + {1'b0, i_b};
            SUB: begin
                o_dout  = i_a - i_b;
                w_carry = (i_a < i_b);
            end
            SRL:  o_dout = i_a >> i_b;
            SLL:  o_dout = i_a << i_b;
            OR:   o_dout = i_a | i_b;
            NOR:  o_dout = ~(i_a | i_b);
            AND:  o_dout = i_a & i_b;
            NAND: o_dout = ~(i_a & i_b);
            XOR:  o_dout = i_a ^ i_b;
            NOT:  o_dout = ~i_a;
            default: o_dout = '0;
        endcase
    end

    always_comb begin
        o_flags             = '0;
        o_flags[ALU_FLAG_C] = w_carry;
        o_flags[ALU_FLAG_Z] = (o_dout == '0);
        o_flags[ALU_FLAG_N] = o_dout[DATA_WIDTH-1];
    end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl.sv
// ============================================================================
// Module : alu_ctrl
// Brief  : Handshaked IDLE/EXEC/RESP wrapper around the ALU, one op per 3 cycles.
//          Define ALU_CTRL_FLAGREG_EN to add the persistent flags_q register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl
    import uurisc_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    input  logic [DATA_WIDTH-1:0]    req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [DATA_WIDTH-1:0]    rsp_flags,
    output logic                     rsp_err,
`ifdef ALU_CTRL_FLAGREG_EN
    output logic [ALU_FLAG_BITS-1:0] flags_q,
`endif
    output logic                     busy
);

    alu_ctrl_state_t          r_state;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [DATA_WIDTH-1:0]    r_op;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [ALU_FLAG_BITS-1:0] r_flags;
    logic                     r_err;
    logic                     r_rsp_valid;

    logic [DATA_WIDTH-1:0]    w_dout;
    logic [ALU_FLAG_BITS-1:0] w_flags;
    logic                     w_illegal;

    assign w_illegal = (r_op > DATA_WIDTH'(ALU_OP_LAST));

    alu_ctrl_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_op    (alu_op_t'(r_op[3:0])),
        .o_dout  (w_dout),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_data      <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
`ifdef ALU_CTRL_FLAGREG_EN
            flags_q     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_op    <= req_op;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal ops still take the EXEC slot so timing is op-independent
                    r_data      <= w_illegal ? '0 : w_dout;
                    r_flags     <= w_illegal ? '0 : w_flags;
                    r_err       <= w_illegal;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
`ifdef ALU_CTRL_FLAGREG_EN
                        if (!r_err) begin
                            flags_q <= r_flags;
                        end
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so no request can be taken while reset is being applied
    assign req_ready = (r_state == IDLE) && rst_n;
    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_data;
    assign rsp_flags = {{(DATA_WIDTH-ALU_FLAG_BITS){1'b0}}, r_flags};
    assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// ============================================================================
// Module : tb_alu_ctrl
// Brief  : Scoreboard bench for alu_ctrl (honours ALU_CTRL_FLAGREG_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [W-1:0] req_op = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic [W-1:0] rsp_flags;
    logic         rsp_err;
    logic         busy;
`ifdef ALU_CTRL_FLAGREG_EN
    logic [2:0]   flags_q;
    logic [2:0]   m_flagsq = 3'd0;
`endif

    alu_ctrl #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
`ifdef ALU_CTRL_FLAGREG_EN
        .flags_q   (flags_q),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] f;
        logic         e;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic prev_rv = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: flags = {negative, zero, carry/borrow}; illegal ops give all zero
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] op);
        exp_t r;
        logic [W:0] s;
        logic c;
        c   = 1'b0;
        r.d = '0;
        case (op)
            16'd0: begin s = {1'b0, a} + {1'b0, b}; r.d = s[W-1:0]; c = s[W]; end
            16'd1: begin r.d = a - b; c = (b > a); end
            16'd2: r.d = (b >= W) ? '0 : (a >> b);
            16'd3: r.d = (b >= W) ? '0 : (a << b);
            16'd4: r.d = a | b;
            16'd5: r.d = ~(a | b);
            16'd6: r.d = a & b;
            16'd7: r.d = ~(a & b);
            16'd8: r.d = a ^ b;
            16'd9: r.d = ~a;
            default: r.d = '0;
        endcase
        r.e = (op > 16'd9);
        r.f = r.e ? '0 : {13'd0, r.d[W-1], (r.d == '0), c};
        if (r.e) r.d = '0;
        r.acc = 0;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            prev_rv <= 1'b0;
`ifdef ALU_CTRL_FLAGREG_EN
            m_flagsq <= 3'd0;
`endif
        end else begin
            if (rsp_valid && !prev_rv) begin
                if (q.size() == 0) check_val("rsp_without_req", rsp_valid, 1'b0);
                else check_val("latency", cyc - q[0].acc, 2);
            end
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                e = q.pop_front();
                check_val("rsp_data", rsp_data, e.d);
                check_val("rsp_flags", rsp_flags, e.f);
                check_val("rsp_err", rsp_err, e.e);
`ifdef ALU_CTRL_FLAGREG_EN
                check_val("flags_q", flags_q, m_flagsq);
                if (!e.e) m_flagsq <= e.f[2:0];
`endif
            end
            if (req_valid && req_ready) begin
                e     = model(req_a, req_b, req_op);
                e.acc = cyc;
                q.push_back(e);
            end
            prev_rv <= rsp_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] op);
        int n = 0;
        @(posedge clk); #1;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        check_val("accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid(input string tag);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, rsp_valid, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", q.size(), 0);
    endtask

    logic [W-1:0] dir_op  [6] = '{16'd0, 16'd1, 16'd3, 16'd2, 16'd6, 16'd8};
    logic [W-1:0] dir_exp [6] = '{16'h035D, 16'h0353, 16'h6B00, 16'h001A, 16'h0000, 16'h035D};

    initial begin
        int       acc_cnt;
        logic [9:0] acc_mask;

        repeat (3) @(negedge clk);
        check_val("rst_req_ready", req_ready, 1'b0);
        check_val("rst_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_rsp_data", rsp_data, 16'h0);
        check_val("rst_rsp_flags", rsp_flags, 16'h0);
        check_val("rst_rsp_err", rsp_err, 1'b0);
`ifdef ALU_CTRL_FLAGREG_EN
        check_val("rst_flags_q", flags_q, 3'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_val("post_rst_req_ready", req_ready, 1'b1);
        check_val("post_rst_busy", busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            send(16'h0358, 16'h0005, dir_op[i]);
            check_val("busy_exec", busy, 1'b1);
            wait_rsp_valid("dir_rsp_valid");
            check_val("dir_data", rsp_data, dir_exp[i]);
            drain();
        end

        for (int i = 0; i < 24; i++) begin
            send(W'($urandom), (i % 2 == 0) ? W'($urandom_range(0, 18)) : W'($urandom),
                 W'($urandom_range(0, 15)));
            wait_rsp_valid("rnd_rsp_valid");
            drain();
        end

        send(16'h0358, 16'h0005, 16'h000C);
        wait_rsp_valid("err_rsp_valid");
        check_val("err_flag", rsp_err, 1'b1);
        check_val("err_data", rsp_data, 16'h0);
        check_val("err_flags", rsp_flags, 16'h0);
        drain();
`ifdef ALU_CTRL_FLAGREG_EN
        @(negedge clk);
        check_val("err_flags_q_hold", flags_q, m_flagsq);
`endif

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(16'h0358, 16'h0005, 16'h0004);
        wait_rsp_valid("bp_rsp_valid");
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", rsp_valid, 1'b1);
            check_val("bp_data", rsp_data, 16'h035D);
            check_val("bp_req_ready", req_ready, 1'b0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_hs_valid", rsp_valid, 1'b1);
        @(negedge clk);
        check_val("bp_after_req_ready", req_ready, 1'b1);
        drain();

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(16'h1234, 16'h0F0F, 16'h0009);
        wait_rsp_valid("rr_rsp_valid");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rr_req_ready_in_rst", req_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rr_rsp_valid", rsp_valid, 1'b0);
        check_val("rr_busy", busy, 1'b0);
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_val("rr_no_rsp", rsp_valid, 1'b0);
        check_val("rr_queue", q.size(), 0);

        @(posedge clk); #1;
        acc_cnt  = 0;
        acc_mask = '0;
        req_a = 16'h0100; req_b = 16'h0003; req_op = 16'h0000;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                acc_cnt++;
                acc_mask[i] = 1'b1;
            end
            @(posedge clk); #1;
            req_a  = req_a + 16'h0011;
            req_op = W'(i % 10);
        end
        req_valid = 1'b0;
        check_val("tp_count", acc_cnt, 4);
        check_val("tp_cycles", acc_mask, 10'h249);
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
